read_unit: RTL and testbench
============================

READ_UNIT -- requirements
Module: read_unit

Interface
REQ-001 SHALL have parameter S, default 8: pointer width, meaning S-1 index bits plus one MSB lap bit.
REQ-002 SHALL have parameter DEPTH, default 100: number of FIFO entries; legal range 2..2^(S-1).
REQ-003 SHALL have parameter AE_LEVEL, default 2: almost-empty threshold in entries.
REQ-004 SHALL have parameter DW, default 8: data width.
REQ-005 SHALL provide the following ports:
  wr_clk  in  1  clock; reset wr_rst, asynchronous, active-high; clock wr_clk
  wr_rst  in  1  asynchronous active-high reset
  rd_en  in  1  read request
  wr_ptr  in  S  write pointer, same {lap, index} encoding as rd_ptr
  mem_rdata  in  DW  storage read data at rd_addr, combinational
  rd_ptr  out  S  read pointer {lap, index}
  rd_addr  out  S-1  storage read index, equal to rd_ptr[S-2:0]
  rd_data  out  DW  registered read data
  o_rd_valid  out  1  rd_data updated this cycle
  o_fifo_empty  out  1  no entries available
  o_almost_empty  out  1  occupancy ≤ AE_LEVEL
  o_count  out  S  occupancy, 0..DEPTH
  o_underflow  out  1  sticky: read attempted while empty

Function
REQ-006 SHALL accept a read when rd_en=1 and o_fifo_empty=0.
REQ-007 On an accepted read with index < DEPTH-1, SHALL increment the index by 1 and hold the lap bit.
REQ-008 On an accepted read with index = DEPTH-1, SHALL clear the index to 0 and invert the lap bit.
REQ-009 SHALL hold rd_ptr unchanged when no read is accepted.
REQ-010 SHALL compute o_fifo_empty combinationally as full pointer equality, wr_ptr == rd_ptr.
REQ-011 SHALL compute o_count combinationally:
  - lap bits equal: w_idx - r_idx
  - lap bits differ: DEPTH - r_idx + w_idx
  - arithmetic performed at S bits, with no overflow for DEPTH ≤ 2^(S-1).
REQ-012 SHALL drive o_almost_empty = (o_count ≤ AE_LEVEL), combinationally.
REQ-013 On an accepted read, SHALL register rd_data <= mem_rdata (sampled at the pre-increment rd_addr) and set o_rd_valid=1 for exactly the next cycle. Latency is 1 cycle from the rd_en edge.
REQ-014 SHALL hold rd_data and drive o_rd_valid=0 when no read is accepted.
REQ-015 On rd_en=1 with o_fifo_empty=1, SHALL leave the pointer unchanged, drive o_rd_valid=0 the next cycle, and set o_underflow=1 until reset.
REQ-016 When wr_ptr changes in the same cycle as a read, empty and count SHALL use the wr_ptr value present at the clock edge; no look-ahead.
REQ-017 At occupancy = DEPTH (lap bits differ, indices equal), SHALL report o_count=DEPTH and o_fifo_empty=0.
REQ-018 SHALL treat wr_ptr as same-clock (wr_clk) and SHALL contain no synchronizers.

Reset
REQ-019 wr_rst=1 SHALL immediately force, independent of clock, all of the following:
  - rd_ptr=0
  - rd_data=0
  - o_rd_valid=0
  - o_underflow=0
REQ-020 Combinational outputs SHALL reflect reset pointers. With wr_ptr also reset, this gives o_fifo_empty=1, o_count=0 and o_almost_empty=1.
REQ-021 Reset asserted mid-burst SHALL discard any in-flight read; no o_rd_valid pulse follows reset release.

Structure
REQ-022 Package fifo_pkg SHALL hold:
  - the S, DEPTH and DW defaults
  - a pointer-increment function (index wrap at DEPTH, lap toggle)
  - an occupancy function
  These are shared with the write side.
REQ-023 Sub-module fifo_ptr_ctr (a lap-bit wrapping pointer register with enable) SHALL implement rd_ptr; the write side reuses the same sub-module.
REQ-024 Elaboration SHALL fail when DEPTH > 2^(S-1) or DEPTH < 2.

Verification (S=4, DEPTH=8, AE_LEVEL=2)
REQ-025 Reset: pulse wr_rst, with wr_ptr=0 -> rd_ptr=0, o_fifo_empty=1, o_count=0, o_almost_empty=1, o_rd_valid=0, o_underflow=0.
REQ-026 Burst: wr_ptr=4'b0011, rd_en=1 for 3 cycles ->
  - rd_ptr goes 1,2,3
  - o_count goes 3,2,1,0
  - o_rd_valid=1 on cycles 2-4, with rd_data equal to mem[0],mem[1],mem[2]
  - o_fifo_empty=1 after the third read
REQ-027 Wrap: rd_ptr=4'b0111, wr_ptr=4'b1001, one read -> rd_ptr=4'b1000, o_count goes 2 to 1, rd_data=mem[7].
REQ-028 Full view: rd_ptr=4'b0000, wr_ptr=4'b1000 -> o_count=8, o_fifo_empty=0, o_almost_empty=0.
REQ-029 Underflow: pointers equal, rd_en=1 -> rd_ptr unchanged, o_rd_valid=0, o_underflow=1, and o_underflow stays 1 after later valid reads.
REQ-030 Mid-burst reset: assert wr_rst between clock edges during a read burst ->
  - outputs reach reset values before the next edge
  - no o_rd_valid pulse after release

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default sizes plus {lap, index} pointer helpers
// used by both the read and write sides.
package fifo_pkg;

  localparam int S_DEFAULT     = 8;
  localparam int DEPTH_DEFAULT = 100;
  localparam int DW_DEFAULT    = 8;

  // Pointers are passed zero-extended to 32 bits; s is the real pointer width.
  function automatic logic [31:0] ptr_next(input logic [31:0] ptr,
                                           input int          s,
                                           input int          depth);
    logic [31:0] lap_bit;
    logic [31:0] idx;
    lap_bit = 32'd1 << (s - 1);
    idx     = ptr & (lap_bit - 32'd1);
    if (idx == 32'(depth - 1))
      return (ptr & lap_bit) ^ lap_bit;
    return (ptr & lap_bit) | (idx + 32'd1);
  endfunction

  // Entries between r and w; differing lap bits mean the writer is one lap ahead.
  function automatic logic [31:0] fifo_occupancy(input logic [31:0] w,
                                                 input logic [31:0] r,
                                                 input int          s,
                                                 input int          depth);
    logic [31:0] lap_bit;
    logic [31:0] w_idx;
    logic [31:0] r_idx;
    lap_bit = 32'd1 << (s - 1);
    w_idx   = w & (lap_bit - 32'd1);
    r_idx   = r & (lap_bit - 32'd1);
    if ((w & lap_bit) == (r & lap_bit))
      return w_idx - r_idx;
    return 32'(depth) - r_idx + w_idx;
  endfunction

endpackage

// File: rtl/fifo_ptr_ctr.sv
// Lap-bit wrapping pointer register: index counts 0..DEPTH-1, lap bit
// toggles on each wrap.
module fifo_ptr_ctr
  import fifo_pkg::*;
#(
  parameter int S     = S_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [S-1:0] ptr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr <= '0;
    else if (en)
      ptr <= S'(ptr_next(32'(ptr), S, DEPTH));
  end

endmodule

// File: rtl/read_unit.sv
// FIFO read side: read pointer, empty/occupancy flags, registered read data
// and a sticky underflow flag. wr_ptr shares the wr_clk domain.
module read_unit
  import fifo_pkg::*;
#(
  parameter int S        = S_DEFAULT,
  parameter int DEPTH    = DEPTH_DEFAULT,
  parameter int AE_LEVEL = 2,
  parameter int DW       = DW_DEFAULT
) (
  input  logic          wr_clk,
  input  logic          wr_rst,
  input  logic          rd_en,
  input  logic [S-1:0]  wr_ptr,
  input  logic [DW-1:0] mem_rdata,
  output logic [S-1:0]  rd_ptr,
  output logic [S-2:0]  rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          o_rd_valid,
  output logic          o_fifo_empty,
  output logic          o_almost_empty,
  output logic [S-1:0]  o_count,
  output logic          o_underflow
);

  generate
    if (S < 2 || S > 32) begin : g_bad_width
      $error("read_unit: S must be in 2..32");
    end
    if (DEPTH < 2 || DEPTH > (1 << (S - 1))) begin : g_bad_depth
      $error("read_unit: DEPTH must be in 2..2^(S-1)");
    end
  endgenerate

  localparam logic [31:0] AE_U = AE_LEVEL;

  logic accept;

  assign o_fifo_empty   = (wr_ptr == rd_ptr);
  assign accept         = rd_en & ~o_fifo_empty;
  assign rd_addr        = rd_ptr[S-2:0];
  assign o_count        = S'(fifo_occupancy(32'(wr_ptr), 32'(rd_ptr), S, DEPTH));
  assign o_almost_empty = (32'(o_count) <= AE_U);

  fifo_ptr_ctr #(
    .S     (S),
    .DEPTH (DEPTH)
  ) u_rd_ptr (
    .clk (wr_clk),
    .rst (wr_rst),
    .en  (accept),
    .ptr (rd_ptr)
  );

  // mem_rdata is sampled while rd_addr still holds the pre-increment index.
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      rd_data     <= '0;
      o_rd_valid  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      o_rd_valid <= accept;
      if (accept)
        rd_data <= mem_rdata;
      if (rd_en && o_fifo_empty)
        o_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_read_unit.sv
// Directed bench for read_unit at S=4, DEPTH=8, AE_LEVEL=2; inputs change and
// outputs are sampled on the falling edge.
module tb_read_unit;

  localparam int S = 4;
  localparam int DEPTH = 8;
  localparam int DW = 8;

  logic          wr_clk = 1'b0;
  logic          wr_rst;
  logic          rd_en;
  logic [S-1:0]  wr_ptr;
  logic [DW-1:0] mem_rdata;
  logic [S-1:0]  rd_ptr;
  logic [S-2:0]  rd_addr;
  logic [DW-1:0] rd_data;
  logic          o_rd_valid;
  logic          o_fifo_empty;
  logic          o_almost_empty;
  logic [S-1:0]  o_count;
  logic          o_underflow;

  logic [DW-1:0] mem [0:DEPTH-1];
  int n_checks = 0;
  int n_fail = 0;

  always #5 wr_clk = ~wr_clk;

  assign mem_rdata = mem[rd_addr];

  read_unit #(.S(S), .DEPTH(DEPTH), .AE_LEVEL(2), .DW(DW)) dut (
    .wr_clk         (wr_clk),
    .wr_rst         (wr_rst),
    .rd_en          (rd_en),
    .wr_ptr         (wr_ptr),
    .mem_rdata      (mem_rdata),
    .rd_ptr         (rd_ptr),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .o_rd_valid     (o_rd_valid),
    .o_fifo_empty   (o_fifo_empty),
    .o_almost_empty (o_almost_empty),
    .o_count        (o_count),
    .o_underflow    (o_underflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(negedge wr_clk);
  endtask

  task automatic do_reset();
    wr_rst = 1'b1;
    tick();
    wr_rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'hA0 + 8'(i);
    wr_rst = 1'b0;
    rd_en  = 1'b0;
    wr_ptr = '0;
    tick();

    // Reset state
    do_reset();
    #1;
    check("rst_rd_ptr", 32'(rd_ptr), 0);
    check("rst_empty", 32'(o_fifo_empty), 1);
    check("rst_count", 32'(o_count), 0);
    check("rst_ae", 32'(o_almost_empty), 1);
    check("rst_valid", 32'(o_rd_valid), 0);
    check("rst_uflow", 32'(o_underflow), 0);

    // Burst of three reads against three entries
    tick();
    wr_ptr = 4'b0011;
    #1;
    check("burst_count0", 32'(o_count), 3);
    check("burst_empty0", 32'(o_fifo_empty), 0);
    rd_en = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      check($sformatf("burst_ptr%0d", c), 32'(rd_ptr), 32'(c));
      check($sformatf("burst_count%0d", c), 32'(o_count), 32'(3 - c));
      check($sformatf("burst_valid%0d", c), 32'(o_rd_valid), 1);
      check($sformatf("burst_data%0d", c), 32'(rd_data), 32'(8'hA0 + c - 1));
    end
    check("burst_empty3", 32'(o_fifo_empty), 1);
    check("burst_ae3", 32'(o_almost_empty), 1);

    // Read while empty: underflow, pointer holds
    tick();
    check("idle_valid", 32'(o_rd_valid), 0);
    check("uflow_ptr", 32'(rd_ptr), 3);
    check("uflow_flag", 32'(o_underflow), 1);
    check("hold_data", 32'(rd_data), 32'hA2);
    wr_ptr = 4'b0101;
    tick();
    check("post_uflow_ptr", 32'(rd_ptr), 4);
    check("post_uflow_valid", 32'(o_rd_valid), 1);
    check("post_uflow_data", 32'(rd_data), 32'hA3);
    check("uflow_sticky", 32'(o_underflow), 1);

    // Asynchronous reset in the middle of a burst
    wr_ptr = 4'b0111;
    tick();
    check("mid_valid_pre", 32'(o_rd_valid), 1);
    #2;
    wr_rst = 1'b1;
    #1;
    check("mid_rst_ptr", 32'(rd_ptr), 0);
    check("mid_rst_valid", 32'(o_rd_valid), 0);
    check("mid_rst_data", 32'(rd_data), 0);
    check("mid_rst_uflow", 32'(o_underflow), 0);
    rd_en  = 1'b0;
    wr_ptr = '0;
    tick();
    wr_rst = 1'b0;
    tick();
    check("mid_rel_valid1", 32'(o_rd_valid), 0);
    tick();
    check("mid_rel_valid2", 32'(o_rd_valid), 0);
    check("mid_rel_ptr", 32'(rd_ptr), 0);

    // Wrap: walk rd_ptr up to index 7, then read across the wrap
    wr_ptr = 4'b0111;
    rd_en  = 1'b1;
    repeat (7) tick();
    rd_en  = 1'b0;
    check("wrap_pre_ptr", 32'(rd_ptr), 32'h7);
    wr_ptr = 4'b1001;
    #1;
    check("wrap_count_pre", 32'(o_count), 2);
    check("wrap_ae_pre", 32'(o_almost_empty), 1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check("wrap_ptr", 32'(rd_ptr), 32'h8);
    check("wrap_count", 32'(o_count), 1);
    check("wrap_data", 32'(rd_data), 32'hA7);
    check("wrap_valid", 32'(o_rd_valid), 1);

    // Full view: laps differ, indices equal
    do_reset();
    wr_ptr = 4'b1000;
    #1;
    check("full_count", 32'(o_count), 8);
    check("full_empty", 32'(o_fifo_empty), 0);
    check("full_ae", 32'(o_almost_empty), 0);
    wr_ptr = 4'b0011;
    #1;
    check("ae_edge_3", 32'(o_almost_empty), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
